apb_slave_regfile: RTL
======================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of read/write registers (1..64).
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, access-phase wait states before PREADY (0..15).
REQ-005 SHALL have port i_PCLK  input  1  bus clock; the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_PRESETn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_PADDR  input  ADDR_WIDTH  byte address.
REQ-008 SHALL have port i_PSEL  input  1  slave select.
REQ-009 SHALL have port i_PENABLE  input  1  access-phase flag.
REQ-010 SHALL have port i_PWRITE  input  1  1 = write, 0 = read.
REQ-011 SHALL have port i_PWDATA  input  DATA_WIDTH  write data.
REQ-012 SHALL have port o_PREADY  output  1  transfer-complete flag.
REQ-013 SHALL have port o_PRDATA  output  DATA_WIDTH  read data.
REQ-014 SHALL have port o_PSLVERR  output  1  transfer error.
REQ-015 SHALL have port i_status  input  DATA_WIDTH  read-only status word.
REQ-016 SHALL have port o_regs  output  NUM_REGS*DATA_WIDTH  flat register contents; register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-017 SHALL have port o_wr_strobe  output  1  one-cycle pulse after each committed write.
REQ-018 SHALL have port o_wr_idx  output  6  index of the last committed write.
REQ-019 SHALL have port o_err_count  output  8  saturating count of PSLVERR responses.

Function
REQ-020 SHALL decode idx = i_PADDR >> 2; idx < NUM_REGS is a R/W register; idx == NUM_REGS is the read-only status word.
REQ-021 SHALL flag an error when i_PADDR[1:0] != 0, idx > NUM_REGS, or a write targets idx == NUM_REGS.
REQ-022 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-023 In IDLE, i_PSEL=1 with i_PENABLE=0 (setup phase) SHALL latch address, direction, write data and error flag, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-024 In IDLE, i_PSEL=1 with i_PENABLE=1 (stale access after completion) SHALL be ignored.
REQ-025 In WAIT, each cycle with i_PSEL=1 and i_PENABLE=1 SHALL decrement the counter; at counter 0 SHALL register o_PREADY=1 together with o_PRDATA and o_PSLVERR, and go to RESP.
REQ-026 With WAIT_CYCLES=0, o_PREADY SHALL be high in the first access-phase cycle; with N wait states, in access cycle N+1.
REQ-027 o_PREADY SHALL be high for exactly one cycle (RESP), then low; RESP SHALL always return to IDLE.
REQ-028 o_PREADY SHALL never be high during a setup phase (i_PENABLE=0).
REQ-029 Read responses SHALL drive o_PRDATA = register[idx] or i_status as sampled at the RESP-entry edge; errored reads and all writes SHALL drive o_PRDATA = 0.
REQ-030 o_PRDATA and o_PSLVERR SHALL be 0 whenever o_PREADY=0.
REQ-031 A write SHALL commit at the edge ending RESP only when i_PSEL=1, i_PENABLE=1 and no error.
REQ-032 Each commit SHALL pulse o_wr_strobe in the following cycle and update o_wr_idx.
REQ-033 Errored writes SHALL leave all registers and o_wr_idx unchanged.
REQ-034 i_PSEL=0 in WAIT or RESP (abort) SHALL return the FSM to IDLE with no commit, o_PREADY=0 and no error count.
REQ-035 o_err_count SHALL increment on each RESP with o_PSLVERR=1 and saturate at 255.

Reset
REQ-036 Asserting i_PRESETn low SHALL immediately force FSM=IDLE, all registers=0, o_PREADY=0, o_PRDATA=0, o_PSLVERR=0, o_wr_strobe=0, o_wr_idx=0, o_err_count=0, regardless of transfer in progress.
REQ-037 After reset release, the first setup phase SHALL be accepted on the first rising edge.

Verification
REQ-038 WAIT_CYCLES=1: write 0xA5A5_0001 to 0x08, read 0x08 -> PREADY in access cycle 2, PRDATA=0xA5A5_0001, PSLVERR=0; o_wr_strobe pulses once with o_wr_idx=2.
REQ-039 Read 0x20 (status, NUM_REGS=8) with i_status=0x1234 -> PRDATA=0x1234; write 0x20 -> PSLVERR=1, regs unchanged, o_err_count=1.
REQ-040 Read 0x06 (misaligned) and 0x40 (out of range) -> PSLVERR=1, PRDATA=0, o_err_count increments per error.
REQ-041 WAIT_CYCLES=0, master holds PSEL=1/PENABLE=1 one cycle after completion, then issues a new setup -> stale cycle ignored, second transfer completes normally.
REQ-042 Drop PSEL mid-WAIT of a write to 0x04 -> no PREADY, reg1 unchanged; reset asserted mid-transfer -> all outputs 0 asynchronously.
REQ-043 Force 300 errored transfers -> o_err_count holds at 255.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB slave exposing NUM_REGS read/write registers plus one read-only
//   status word. Every access takes WAIT_CYCLES wait states before PREADY.
//   Misaligned, out-of-range and status-write accesses return PSLVERR.
//   Errored transfers are counted in a saturating 8-bit counter.
//
// Ports
//   i_PCLK, i_PRESETn          bus clock, asynchronous active-low reset
//   i_PADDR .. i_PWDATA        APB requester signals
//   o_PREADY, o_PRDATA,
//   o_PSLVERR                  APB completer response, all registered
//   i_status                   read-only word at index NUM_REGS
//   o_regs                     flat register contents, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_wr_strobe, o_wr_idx      one-cycle pulse and index after each committed write
//   o_err_count                saturating count of PSLVERR responses

module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                           i_PCLK,
    input  logic                           i_PRESETn,
    input  logic [ADDR_WIDTH-1:0]          i_PADDR,
    input  logic                           i_PSEL,
    input  logic                           i_PENABLE,
    input  logic                           i_PWRITE,
    input  logic [DATA_WIDTH-1:0]          i_PWDATA,
    output logic                           o_PREADY,
    output logic [DATA_WIDTH-1:0]          o_PRDATA,
    output logic                           o_PSLVERR,
    input  logic [DATA_WIDTH-1:0]          i_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic                           o_wr_strobe,
    output logic [5:0]                     o_wr_idx,
    output logic [7:0]                     o_err_count
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [IDX_W-1:0]       lat_idx;
    logic                   lat_write;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic                   lat_err;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

    logic                   setup_err;
    logic [DATA_WIDTH-1:0]  setup_rdata;
    logic [DATA_WIDTH-1:0]  lat_rdata;

    function automatic logic decode_err(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic                  wr);
        logic [IDX_W-1:0] idx;
        idx = addr[ADDR_WIDTH-1:2];
        return (addr[1:0] != 2'b00) || (idx > STATUS_IDX) ||
               (wr && (idx == STATUS_IDX));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_word(input logic [IDX_W-1:0] idx);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        if (idx == STATUS_IDX)
            w = i_status;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (idx == IDX_W'(k))
                w = regs[k];
        end
        return w;
    endfunction

    assign setup_err   = decode_err(i_PADDR, i_PWRITE);
    assign setup_rdata = read_word(i_PADDR[ADDR_WIDTH-1:2]);
    assign lat_rdata   = read_word(lat_idx);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    // With zero wait states the response must already be visible in the
    // first access cycle, so it is registered at the setup edge straight
    // from the live bus and WAIT is skipped. Otherwise the counter is loaded
    // with WAIT_CYCLES and the response is registered on the access cycle
    // whose decrement would bring it to zero.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_idx     <= '0;
            lat_write   <= 1'b0;
            lat_wdata   <= '0;
            lat_err     <= 1'b0;
            o_PREADY    <= 1'b0;
            o_PRDATA    <= '0;
            o_PSLVERR   <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_wr_idx    <= '0;
            o_err_count <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++)
                regs[k] <= '0;
        end else begin
            o_wr_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_PREADY  <= 1'b0;
                    o_PRDATA  <= '0;
                    o_PSLVERR <= 1'b0;
                    // PSEL with PENABLE already high is a stale access; ignore it.
                    if (i_PSEL && !i_PENABLE) begin
                        lat_idx   <= i_PADDR[ADDR_WIDTH-1:2];
                        lat_write <= i_PWRITE;
                        lat_wdata <= i_PWDATA;
                        lat_err   <= setup_err;
                        cnt       <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            o_PREADY  <= 1'b1;
                            o_PSLVERR <= setup_err;
                            o_PRDATA  <= (!i_PWRITE && !setup_err) ? setup_rdata : '0;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!i_PSEL) begin
                        state <= ST_IDLE;
                    end else if (i_PENABLE) begin
                        if (cnt == 4'd1) begin
                            o_PREADY  <= 1'b1;
                            o_PSLVERR <= lat_err;
                            o_PRDATA  <= (!lat_write && !lat_err) ? lat_rdata : '0;
                            state     <= ST_RESP;
                        end
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    o_PREADY  <= 1'b0;
                    o_PRDATA  <= '0;
                    o_PSLVERR <= 1'b0;
                    state     <= ST_IDLE;
                    // A transfer abandoned in RESP neither commits nor counts.
                    if (i_PSEL && i_PENABLE) begin
                        if (o_PSLVERR && (o_err_count != 8'hFF))
                            o_err_count <= o_err_count + 8'd1;
                        if (lat_write && !lat_err) begin
                            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                                if (lat_idx == IDX_W'(k))
                                    regs[k] <= lat_wdata;
                            end
                            o_wr_strobe <= 1'b1;
                            o_wr_idx    <= 6'(lat_idx);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
